// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write scoreboard,
// writeback-to-decode operand bypass and an {n,z,p} condition-code register.
// The RAW/WAW stall for decode is generated here from the scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter int AW       = $clog2(NREGS),
    parameter int PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    // Decode request
    input  logic             issue_valid,
    input  logic             need_a,
    input  logic             need_b,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    input  logic             has_dest,
    input  logic [AW-1:0]    issue_dest,
    output logic             stall,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    // Writeback
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_dest,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             wb_setcc,
    // Mispredict squash
    input  logic             flush,
    output logic [2:0]       cc
);

    localparam int CW = $clog2(PEND_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(PEND_MAX);

    logic [NREGS-1:0][WIDTH-1:0] rf_q;
    logic [NREGS-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [2:0]                  cc_q, cc_d;

    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] busy;
    logic             dest_full;
    logic             issue_fire;

    // Per-register writeback match and effective busy; a register whose last
    // outstanding write retires this cycle is free because the bypass covers it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        wb_hit = '0;
        busy   = '0;
        for (int r = 0; r < NREGS; r++) begin
            wb_hit[r] = wb_valid && (wb_dest == AW'(r));
            busy[r]   = cnt_t'(cnt_q[r]) > (wb_hit[r] ? cnt_t'(1) : cnt_t'(0));
        end
    end

    // Hazard detection: RAW on either needed source, WAW when the destination
    // already has the maximum number of outstanding writes.
    always_comb begin
        dest_full  = (cnt_t'(cnt_q[issue_dest]) == CNT_MAX) && !wb_hit[issue_dest];
        stall      = issue_valid && ((need_a && busy[src_a]) ||
                                     (need_b && busy[src_b]) ||
                                     (has_dest && dest_full));
        issue_fire = issue_valid && !stall && !flush;
    end

    // Operand read with writeback bypass; applies whether or not the register is pending.
    assign reg_a = wb_hit[src_a] ? wb_data : rf_q[src_a];
    assign reg_b = wb_hit[src_b] ? wb_data : rf_q[src_b];
    assign cc    = cc_q;

    // Pending-count next state; flush clears everything, a simultaneous
    // issue and retire to the same register leaves its count unchanged.
    always_comb begin
        logic inc;
        logic dec;
        inc   = 1'b0;
        dec   = 1'b0;
        cnt_d = cnt_q;
        for (int r = 0; r < NREGS; r++) begin
            inc = issue_fire && has_dest && (issue_dest == AW'(r));
            dec = wb_hit[r] && (cnt_q[r] != '0);
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + cnt_t'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - cnt_t'(1);
            end
        end
    end

    // Condition codes from the retiring value when requested, otherwise held.
    always_comb begin
        cc_d = cc_q;
        if (wb_valid && wb_setcc) begin
            cc_d = {wb_data[WIDTH-1],
                    wb_data == '0,
                    !wb_data[WIDTH-1] && (wb_data != '0)};
        end
    end

    // State registers; reset wins over writeback, issue and flush.
    always_ff @(posedge clk) begin
        // NOTE: the register array is reset explicitly because architectural state must read 0 after reset; plain storage arrays normally are not.
        if (reset) begin
            rf_q  <= '0;
            cnt_q <= '0;
            cc_q  <= 3'b010;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (wb_valid) begin
                rf_q[wb_dest] <= wb_data;
            end
            cnt_q <= cnt_d;
            cc_q  <= cc_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a behavioural model computes
// the expected outputs as stimulus is driven, pushes them into a queue, and
// the entry is popped and compared against the DUT outputs before the edge.
module tb_regfile_scoreboard;

    localparam int WIDTH    = 16;
    localparam int NREGS    = 8;
    localparam int AW       = 3;
    localparam int PEND_MAX = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid, need_a, need_b, has_dest;
    logic [AW-1:0]    src_a, src_b, issue_dest;
    logic             stall;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic             wb_valid, wb_setcc, flush;
    logic [AW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;
    logic [2:0]       cc;

    regfile_scoreboard #(
        .WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .PEND_MAX(PEND_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .need_a(need_a), .need_b(need_b),
        .src_a(src_a), .src_b(src_b), .has_dest(has_dest), .issue_dest(issue_dest),
        .stall(stall), .reg_a(reg_a), .reg_b(reg_b),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_setcc(wb_setcc),
        .flush(flush), .cc(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic             stall;
        logic [WIDTH-1:0] reg_a;
        logic [WIDTH-1:0] reg_b;
        logic [2:0]       cc;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural reference state
    logic [WIDTH-1:0] m_rf  [NREGS];
    int               m_cnt [NREGS];
    logic [2:0]       m_cc;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic m_busy(input int r);
        int hit;
        hit = (wb_valid && int'(wb_dest) == r) ? 1 : 0;
        return m_cnt[r] > hit;
    endfunction

    function automatic logic m_stall();
        logic full;
        full = (m_cnt[issue_dest] == PEND_MAX) && !(wb_valid && wb_dest == issue_dest);
        return issue_valid && ((need_a && m_busy(int'(src_a))) ||
                               (need_b && m_busy(int'(src_b))) ||
                               (has_dest && full));
    endfunction

    function automatic logic [WIDTH-1:0] m_read(input logic [AW-1:0] s);
        if (wb_valid && wb_dest == s) return wb_data;
        return m_rf[s];
    endfunction

    task automatic idle();
        reset = 1'b0; issue_valid = 1'b0; need_a = 1'b0; need_b = 1'b0; has_dest = 1'b0;
        src_a = '0; src_b = '0; issue_dest = '0;
        wb_valid = 1'b0; wb_dest = '0; wb_data = '0; wb_setcc = 1'b0; flush = 1'b0;
    endtask

    // Push expected outputs for the current inputs, then pop and compare.
    task automatic eval(input string tag);
        exp_t e;
        e.tag   = tag;
        e.stall = m_stall();
        e.reg_a = m_read(src_a);
        e.reg_b = m_read(src_b);
        e.cc    = m_cc;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({e.tag, "_stall"}, 32'(stall), 32'(e.stall));
        check({e.tag, "_reg_a"}, 32'(reg_a), 32'(e.reg_a));
        check({e.tag, "_reg_b"}, 32'(reg_b), 32'(e.reg_b));
        check({e.tag, "_cc"},    32'(cc),    32'(e.cc));
    endtask

    // Advance the model with the current inputs across one rising edge.
    task automatic tick();
        logic [WIDTH-1:0] n_rf  [NREGS];
        int               n_cnt [NREGS];
        logic [2:0]       n_cc;
        logic             fire;
        fire  = issue_valid && !m_stall() && !flush;
        n_rf  = m_rf;
        n_cnt = m_cnt;
        n_cc  = m_cc;
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                n_rf[r]  = '0;
                n_cnt[r] = 0;
            end
            n_cc = 3'b010;
        end else begin
            if (wb_valid) n_rf[wb_dest] = wb_data;
            if (wb_valid && wb_setcc)
                n_cc = wb_data[15] ? 3'b100 : (wb_data == 16'h0 ? 3'b010 : 3'b001);
            for (int r = 0; r < NREGS; r++) begin
                if (flush) n_cnt[r] = 0;
                else begin
                    if (fire && has_dest && int'(issue_dest) == r) n_cnt[r]++;
                    if (wb_valid && int'(wb_dest) == r && m_cnt[r] != 0) n_cnt[r]--;
                end
            end
        end
        @(posedge clk);
        m_rf  = n_rf;
        m_cnt = n_cnt;
        m_cc  = n_cc;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_rf[r]  = 'x;
            m_cnt[r] = 0;
        end
        m_cc = 'x;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state: all registers read 0, cc = 010, no stall
        for (int i = 0; i < NREGS; i++) begin
            src_a = AW'(i); src_b = AW'(NREGS - 1 - i);
            issue_valid = 1'b1; need_a = 1'b1; need_b = 1'b1;
            eval($sformatf("rst_r%0d", i));
        end
        check("rst_cc_const", 32'(cc), 32'(3'b010));
        idle();
        tick();

        // RAW on R3 held until writeback, which bypasses and releases
        issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd3;
        eval("raw_issue");
        tick();
        idle(); issue_valid = 1'b1; need_a = 1'b1; src_a = 3'd3;
        for (int i = 0; i < 3; i++) begin
            eval($sformatf("raw_hold%0d", i));
            check("raw_hold_const", 32'(stall), 32'(1'b1));
            tick();
        end
        wb_valid = 1'b1; wb_dest = 3'd3; wb_data = 16'h00A5;
        eval("raw_wb");
        check("raw_wb_stall_const", 32'(stall), 32'(1'b0));
        check("raw_wb_bypass_const", 32'(reg_a), 32'h00A5);
        tick();
        idle(); issue_valid = 1'b1; need_a = 1'b1; src_a = 3'd3;
        eval("raw_after");
        check("raw_after_const", 32'(stall), 32'(1'b0));
        tick();

        // WAW saturation on R2
        idle(); issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd2;
        for (int i = 0; i < PEND_MAX; i++) begin
            eval($sformatf("waw_issue%0d", i));
            tick();
        end
        eval("waw_full");
        check("waw_full_const", 32'(stall), 32'(1'b1));
        tick();
        wb_valid = 1'b1; wb_dest = 3'd2; wb_data = 16'h0022;
        eval("waw_wb_accept");
        check("waw_wb_accept_const", 32'(stall), 32'(1'b0));
        tick();
        wb_valid = 1'b0;
        eval("waw_still_full");
        check("waw_still_full_const", 32'(stall), 32'(1'b1));
        // A read of R2 stays blocked when more than one write remains
        has_dest = 1'b0; need_a = 1'b1; src_a = 3'd2;
        wb_valid = 1'b1; wb_dest = 3'd2; wb_data = 16'h0033;
        eval("waw_read_busy");
        tick();

        // Flush clears counters; issue in the flush cycle is not accepted
        idle(); issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd5;
        eval("fl_issue");
        tick();
        issue_dest = 3'd6; flush = 1'b1;
        eval("fl_flush");
        tick();
        idle(); issue_valid = 1'b1; need_a = 1'b1; src_a = 3'd5; need_b = 1'b1; src_b = 3'd6;
        eval("fl_dep");
        check("fl_dep_const", 32'(stall), 32'(1'b0));
        tick();
        idle(); wb_valid = 1'b1; wb_dest = 3'd5; wb_data = 16'h1234;
        eval("fl_late_wb");
        tick();
        idle(); issue_valid = 1'b1; need_a = 1'b1; src_a = 3'd5;
        eval("fl_read");
        check("fl_read_const", 32'(reg_a), 32'h1234);
        tick();
        // Counter must still be 0: three issues accepted before the WAW limit
        idle(); issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd5;
        for (int i = 0; i <= PEND_MAX; i++) begin
            eval($sformatf("fl_cnt%0d", i));
            tick();
        end
        idle(); flush = 1'b1;
        tick();

        // Condition codes
        begin
            logic [WIDTH-1:0] cc_data [4];
            logic             cc_set  [4];
            logic [2:0]       cc_want [4];
            cc_data = '{16'h8000, 16'h0000, 16'h0001, 16'h8000};
            cc_set  = '{1'b1, 1'b1, 1'b1, 1'b0};
            cc_want = '{3'b100, 3'b010, 3'b001, 3'b001};
            for (int i = 0; i < 4; i++) begin
                idle(); wb_valid = 1'b1; wb_dest = 3'd4; wb_data = cc_data[i]; wb_setcc = cc_set[i];
                eval($sformatf("cc_wb%0d", i));
                tick();
                idle();
                eval($sformatf("cc_after%0d", i));
                check($sformatf("cc_const%0d", i), 32'(cc), 32'(cc_want[i]));
            end
        end

        // Reset mid-flight with R1 pending twice and a simultaneous writeback
        idle(); wb_valid = 1'b1; wb_dest = 3'd1; wb_data = 16'h7777;
        tick();
        idle(); issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd1;
        tick();
        tick();
        idle(); reset = 1'b1; issue_valid = 1'b1; has_dest = 1'b1; issue_dest = 3'd1;
        wb_valid = 1'b1; wb_dest = 3'd1; wb_data = 16'h5555; wb_setcc = 1'b1;
        tick();
        idle(); issue_valid = 1'b1; need_a = 1'b1; src_a = 3'd1; need_b = 1'b1; src_b = 3'd2;
        eval("mrst");
        check("mrst_stall_const", 32'(stall), 32'(1'b0));
        check("mrst_r1_const", 32'(reg_a), 32'h0000);
        check("mrst_cc_const", 32'(cc), 32'(3'b010));
        tick();

        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised decode-stage register file for the LC-3b pipeline. Generalises the plain regfile with a per-register pending-write scoreboard, writeback-to-decode bypass, and a condition-code register.
- Produces the decode stall signal for RAW and WAW hazards, so no separate hazard unit is needed.
- Sits between instruction decode, which issues requests, and the WB stage, which retires writes.

Parameters:
- WIDTH, 16: data word width in bits.
- NREGS, 8: number of architectural registers.
- AW, $clog2(NREGS): register index width.
- PEND_MAX, 3: maximum outstanding writes per register. Counter width is $clog2(PEND_MAX+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- need_a  in  1  instruction reads src_a.
- need_b  in  1  instruction reads src_b.
- src_a  in  AW  source register A index.
- src_b  in  AW  source register B index.
- has_dest  in  1  instruction will write a register.
- issue_dest  in  AW  destination register index.
- stall  out  1  decode must hold the instruction; issue is not accepted.
- reg_a  out  WIDTH  operand A, bypassed.
- reg_b  out  WIDTH  operand B, bypassed.
- wb_valid  in  1  WB stage retires a register write.
- wb_dest  in  AW  writeback register index.
- wb_data  in  WIDTH  writeback data.
- wb_setcc  in  1  update the condition codes from wb_data (requires wb_valid).
- flush  in  1  squash all in-flight issued writes (branch mispredict).
- cc  out  3  {n,z,p} condition codes.

Behaviour:
- Reset (synchronous, active-high):
  - All registers are 0.
  - All pending counters are 0.
  - cc = 3'b010.
  - Therefore stall = 0, reg_a = reg_b = 0.
  - Reset overrides issue, writeback and flush in the same cycle.
- Reads are combinational:
  - reg_x = wb_data if wb_valid && wb_dest == src_x.
  - Otherwise reg_x = rf[src_x].
  - Bypass applies even if the register is not pending.
- Write: rf[wb_dest] <= wb_data at the rising edge when wb_valid.
- Effective busy:
  - busy(r) = cnt[r] > (wb_valid && wb_dest == r ? 1 : 0).
  - A register whose last pending write retires this cycle is not busy; its operand comes from the bypass.
- stall = issue_valid && ((need_a && busy(src_a)) || (need_b && busy(src_b)) || (has_dest && cnt[issue_dest] == PEND_MAX && !(wb_valid && wb_dest == issue_dest))).
  - stall is purely combinational; it has zero-cycle latency.
- Issue acceptance: issue_fire = issue_valid && !stall && !flush.
  - If has_dest, cnt[issue_dest] increments.
- Counter update per register r:
  - inc = issue_fire && has_dest && issue_dest == r.
  - dec = wb_valid && wb_dest == r && cnt[r] != 0.
  - If inc and dec are both true, the counter is unchanged.
  - Decrement saturates at 0.
  - Increment never exceeds PEND_MAX, guaranteed by the stall rule.
- flush:
  - All counters become 0 at the edge. This overrides inc and dec.
  - The same-cycle writeback data and CC are still written.
  - Later writebacks from squashed instructions still write the register file but do not decrement (saturation).
  - No issue is accepted in the flush cycle.
- Condition codes:
  - On wb_valid && wb_setcc: cc <= {wb_data[WIDTH-1], wb_data == 0, !wb_data[WIDTH-1] && wb_data != 0}.
  - Otherwise cc holds its value.
  - cc is not bypassed; consumers see the update the cycle after writeback.
- Same-register read and write in one issued instruction (e.g. ADD R1,R1,R2): reads use the pre-issue state; the dest counter increments after.
- wb_valid to a register with cnt = 0 is legal. The data is written and the counter stays at 0.

Test Plan:
- Reset, then read R0..R7 with no writeback -> reg_a = reg_b = 0, cc = 3'b010, stall = 0.
- Issue has_dest R3. Next cycle issue need_a src_a=R3 -> stall = 1. Holds 1 until the cycle wb_valid with wb_dest=R3, wb_data=16'h00A5. In that cycle stall = 0 and reg_a = 16'h00A5. The cycle after, cnt[R3] = 0.
- Issue has_dest R2 four times, no writeback (PEND_MAX=3) -> 4th issue stalls. Same cycle wb to R2 -> 4th accepted, cnt[R2] stays 3.
- Issue dest R5, then flush -> cnt[R5] = 0, a dependent read of R5 does not stall. A later wb to R5 of 16'h1234 writes the register file, cnt stays 0.
- wb_valid, wb_setcc with data 16'h8000 -> cc = 3'b100 next cycle. Data 0 -> 3'b010. Data 16'h0001 -> 3'b001. wb_setcc=0 -> cc unchanged.
- reset asserted mid-flight with cnt[R1] = 2 and a simultaneous wb -> after the edge, all counters are 0, rf[R1] = 0, cc = 3'b010.
